// File: rtl/draw_arbiter.sv
// draw_arbiter: shares the single rectangle drawer between the left paddle
// (requester 0), the right paddle (requester 1) and the ball (requester 2).
// After reset it clears the whole screen once. It then grants one requester
// at a time in round-robin order, draws its rectangle and pulses req_ready
// to release it to its next position update.
//
// Build option: define DRAW_ARB_ERASE_EN to erase a requester's previously
// drawn rectangle (in BG_COLOR) before drawing it at a new position.
//
// Handshake: a drawer command transfers on a rising clock edge where d_valid
// and d_ready are both high. d_valid and all command fields hold steady until
// that edge, and d_valid drops the cycle after. d_done pulses once, some
// cycles after the transfer, when that rectangle is finished.
//
// Every output is a flop loaded from the next-state decode, so all outputs
// are 0 while reset is asserted. state_dbg shows the current FSM state.
module draw_arbiter #(
  parameter logic [8:0] SCREEN_WIDTH  = 9'd320,
  parameter logic [8:0] SCREEN_HEIGHT = 9'd240,
  parameter logic [8:0] PADDLE_WIDTH  = 9'd10,
  parameter logic [8:0] PADDLE_HEIGHT = 9'd48,
  parameter logic [8:0] BALL_WIDTH    = 9'd4,
  parameter logic [8:0] BALL_HEIGHT   = 9'd4,
  parameter logic [2:0] BG_COLOR      = 3'b000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  req_valid,
  input  logic [26:0] req_x,
  input  logic [26:0] req_y,
  input  logic [8:0]  req_color,
  output logic [2:0]  req_ready,
  output logic        d_valid,
  input  logic        d_ready,
  input  logic        d_done,
  output logic [8:0]  d_x,
  output logic [8:0]  d_y,
  output logic [8:0]  d_w,
  output logic [8:0]  d_h,
  output logic [2:0]  d_color,
  output logic        busy,
  output logic [15:0] frames_drawn,
  output logic [3:0]  state_dbg
);

  typedef enum logic [3:0] {
    S_INIT       = 4'd0,
    S_CLEAR_REQ  = 4'd1,
    S_CLEAR_WAIT = 4'd2,
    S_IDLE       = 4'd3,
    S_ERASE_REQ  = 4'd4,
    S_ERASE_WAIT = 4'd5,
    S_DRAW_REQ   = 4'd6,
    S_DRAW_WAIT  = 4'd7,
    S_ACK        = 4'd8
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  rr_q, rr_d;
  logic [1:0]  grant_q, grant_d;
  logic [8:0]  cmd_x_q, cmd_x_d;
  logic [8:0]  cmd_y_q, cmd_y_d;
  logic [2:0]  cmd_c_q, cmd_c_d;
  logic [2:0]  drawn_q, drawn_d;
  logic [15:0] frames_q, frames_d;

  logic        d_valid_q, d_valid_d;
  logic [8:0]  d_x_q, d_x_d, d_y_q, d_y_d, d_w_q, d_w_d, d_h_q, d_h_d;
  logic [2:0]  d_color_q, d_color_d;
  logic [2:0]  req_ready_q, req_ready_d;
  logic        busy_q, busy_d;

  logic [8:0]  rx [3];
  logic [8:0]  ry [3];
  logic [2:0]  rc [3];
  logic [1:0]  pick, p1, p2;
  logic        erase_needed;

`ifdef DRAW_ARB_ERASE_EN
  logic [8:0]  old_x_q [3];
  logic [8:0]  old_x_d [3];
  logic [8:0]  old_y_q [3];
  logic [8:0]  old_y_d [3];
`endif

  function automatic logic [8:0] size_w(input logic [1:0] g);
    return (g == 2'd2) ? BALL_WIDTH : PADDLE_WIDTH;
  endfunction

  function automatic logic [8:0] size_h(input logic [1:0] g);
    return (g == 2'd2) ? BALL_HEIGHT : PADDLE_HEIGHT;
  endfunction

  // Split the packed requester buses and pick the round-robin winner.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      rx[i] = req_x[9*i +: 9];
      ry[i] = req_y[9*i +: 9];
      rc[i] = req_color[3*i +: 3];
    end
    p1 = (rr_q == 2'd2) ? 2'd0 : rr_q + 2'd1;
    p2 = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
    if (req_valid[rr_q])    pick = rr_q;
    else if (req_valid[p1]) pick = p1;
    else                    pick = p2;
`ifdef DRAW_ARB_ERASE_EN
    erase_needed = drawn_q[pick] &&
                   ((rx[pick] != old_x_q[pick]) || (ry[pick] != old_y_q[pick]));
`else
    erase_needed = 1'b0;
`endif
  end

  // Next-state logic: startup clear, grant, erase/draw sequencing, ack.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    grant_d  = grant_q;
    cmd_x_d  = cmd_x_q;
    cmd_y_d  = cmd_y_q;
    cmd_c_d  = cmd_c_q;
    drawn_d  = drawn_q;
    frames_d = frames_q;
`ifdef DRAW_ARB_ERASE_EN
    old_x_d  = old_x_q;
    old_y_d  = old_y_q;
`endif
    case (state_q)
      S_INIT:       state_d = S_CLEAR_REQ;
      S_CLEAR_REQ:  if (d_ready) state_d = S_CLEAR_WAIT;
      S_CLEAR_WAIT: if (d_done) state_d = S_IDLE;
      S_IDLE: begin
        if (|req_valid) begin
          grant_d = pick;
          cmd_x_d = rx[pick];
          cmd_y_d = ry[pick];
          cmd_c_d = rc[pick];
          state_d = erase_needed ? S_ERASE_REQ : S_DRAW_REQ;
        end
      end
      S_ERASE_REQ:  if (d_ready) state_d = S_ERASE_WAIT;
      S_ERASE_WAIT: if (d_done) state_d = S_DRAW_REQ;
      S_DRAW_REQ:   if (d_ready) state_d = S_DRAW_WAIT;
      S_DRAW_WAIT: begin
        if (d_done) begin
          drawn_d[grant_q] = 1'b1;
          frames_d         = frames_q + 16'd1;
`ifdef DRAW_ARB_ERASE_EN
          old_x_d[grant_q] = cmd_x_q;
          old_y_d[grant_q] = cmd_y_q;
`endif
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        rr_d    = (grant_q == 2'd2) ? 2'd0 : grant_q + 2'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  // Output decode from the state being entered, registered with the state.
  always_comb begin
    d_valid_d   = 1'b0;
    d_x_d       = '0;
    d_y_d       = '0;
    d_w_d       = '0;
    d_h_d       = '0;
    d_color_d   = '0;
    req_ready_d = '0;
    busy_d      = (state_d != S_IDLE);
    case (state_d)
      S_CLEAR_REQ: begin
        d_valid_d = 1'b1;
        d_w_d     = SCREEN_WIDTH;
        d_h_d     = SCREEN_HEIGHT;
        d_color_d = BG_COLOR;
      end
`ifdef DRAW_ARB_ERASE_EN
      S_ERASE_REQ: begin
        d_valid_d = 1'b1;
        d_x_d     = old_x_q[grant_d];
        d_y_d     = old_y_q[grant_d];
        d_w_d     = size_w(grant_d);
        d_h_d     = size_h(grant_d);
        d_color_d = BG_COLOR;
      end
`endif
      S_DRAW_REQ: begin
        d_valid_d = 1'b1;
        d_x_d     = cmd_x_d;
        d_y_d     = cmd_y_d;
        d_w_d     = size_w(grant_d);
        d_h_d     = size_h(grant_d);
        d_color_d = cmd_c_d;
      end
      S_ACK:   req_ready_d[grant_d] = 1'b1;
      default: ;
    endcase
  end

  // State, command and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_INIT;
      rr_q        <= '0;
      grant_q     <= '0;
      cmd_x_q     <= '0;
      cmd_y_q     <= '0;
      cmd_c_q     <= '0;
      drawn_q     <= '0;
      frames_q    <= '0;
      d_valid_q   <= 1'b0;
      d_x_q       <= '0;
      d_y_q       <= '0;
      d_w_q       <= '0;
      d_h_q       <= '0;
      d_color_q   <= '0;
      req_ready_q <= '0;
      busy_q      <= 1'b0;
`ifdef DRAW_ARB_ERASE_EN
      for (int i = 0; i < 3; i++) begin
        old_x_q[i] <= '0;
        old_y_q[i] <= '0;
      end
`endif
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      cmd_x_q     <= cmd_x_d;
      cmd_y_q     <= cmd_y_d;
      cmd_c_q     <= cmd_c_d;
      drawn_q     <= drawn_d;
      frames_q    <= frames_d;
      d_valid_q   <= d_valid_d;
      d_x_q       <= d_x_d;
      d_y_q       <= d_y_d;
      d_w_q       <= d_w_d;
      d_h_q       <= d_h_d;
      d_color_q   <= d_color_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
`ifdef DRAW_ARB_ERASE_EN
      old_x_q     <= old_x_d;
      old_y_q     <= old_y_d;
`endif
    end
  end

  assign d_valid      = d_valid_q;
  assign d_x          = d_x_q;
  assign d_y          = d_y_q;
  assign d_w          = d_w_q;
  assign d_h          = d_h_q;
  assign d_color      = d_color_q;
  assign req_ready    = req_ready_q;
  assign busy         = busy_q;
  assign frames_drawn = frames_q;
  assign state_dbg    = state_q;

endmodule
